// File: rtl/bus_router.sv
// bus_router: routes the CPU byte bus and the HCI debug master onto the internal
// RAM and the HCI I/O port, steering read data back by a latency-matched tag.
//
// Ports:
//   clk_in, rst_in             clock, asynchronous active-high reset
//   cpu_a/cpu_wr/cpu_dout      CPU request; cpu_din/cpu_rdy back to CPU
//   dbg_req/dbg_a/dbg_wr/...   debug master request; dbg_grant/dbg_din back
//   ram_*                      RAM slave (ram_r_nw: 1 = read)
//   io_*                       I/O slave (io_full: transmit buffer full)
//
// Optional feature: define BUS_ROUTER_IO_STALL_EN to hold CPU writes to the
// I/O region while io_full is set; otherwise such writes pass straight through.
module bus_router #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int READ_LATENCY   = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [31:0]               cpu_a,
  input  logic                      cpu_wr,
  input  logic [7:0]                cpu_dout,
  output logic [7:0]                cpu_din,
  output logic                      cpu_rdy,
  input  logic                      dbg_req,
  output logic                      dbg_grant,
  input  logic [RAM_ADDR_WIDTH-1:0] dbg_a,
  input  logic                      dbg_wr,
  input  logic [7:0]                dbg_dout,
  output logic [7:0]                dbg_din,
  output logic                      ram_en,
  output logic                      ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]                ram_d_in,
  input  logic [7:0]                ram_d_out,
  output logic                      io_en,
  output logic [IO_SEL_WIDTH-1:0]   io_sel,
  output logic                      io_wr,
  output logic [7:0]                io_din,
  input  logic [7:0]                io_dout,
  input  logic                      io_full
);
  typedef enum logic [1:0] {S_CPU, S_DRAIN_D, S_DBG, S_DRAIN_C} state_t;
  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [1:0]  tag [READ_LATENCY];
  logic [31:0] addr;
  logic [7:0]  data;
  logic        own_cpu, own_dbg, valid, wr, is_io, stall, drain_done, unused;
  always_comb begin
    own_cpu = state == S_CPU;
    own_dbg = state == S_DBG;
    valid   = own_cpu | own_dbg;
    addr    = own_dbg ? 32'(dbg_a) : cpu_a;
    data    = own_dbg ? dbg_dout : cpu_dout;
    wr      = valid & (own_dbg ? dbg_wr : cpu_wr);
    is_io   = addr[RAM_ADDR_WIDTH -: 2] == 2'b11;
  end
`ifdef BUS_ROUTER_IO_STALL_EN
  assign stall  = own_cpu & cpu_wr & is_io & io_full;
  assign unused = ^addr[31:RAM_ADDR_WIDTH+1];
`else
  assign stall  = 1'b0;
  assign unused = ^{addr[31:RAM_ADDR_WIDTH+1], io_full};
`endif
  assign ram_en    = valid & ~is_io;
  assign io_en     = valid & is_io & ~stall;
  assign ram_r_nw  = ~wr;
  assign io_wr     = wr;
  assign ram_a     = addr[RAM_ADDR_WIDTH-1:0];
  assign io_sel    = addr[IO_SEL_WIDTH-1:0];
  assign ram_d_in  = data;
  assign io_din    = data;
  assign dbg_din   = ram_d_out;
  assign cpu_rdy   = own_cpu & ~stall;
  assign dbg_grant = own_dbg;
  // the last stage describes the access issued READ_LATENCY cycles ago
  assign cpu_din   = tag[READ_LATENCY-1] == 2'b11 ? io_dout : ram_d_out;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) tag[i] <= '0;
    end else begin
      tag[0] <= {ram_en | io_en, io_en};
      for (int i = 1; i < READ_LATENCY; i++) tag[i] <= tag[i-1];
    end
  end
  // a drain lasts READ_LATENCY cycles so every in-flight read retires on idle bus
  assign drain_done = cnt == 3'(READ_LATENCY - 1);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_CPU;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_CPU:     state_nxt = dbg_req ? S_DRAIN_D : S_CPU;
      S_DRAIN_D: begin
        state_nxt = drain_done ? S_DBG : S_DRAIN_D;
        cnt_nxt   = drain_done ? 3'd0 : cnt + 3'd1;
      end
      S_DBG:     state_nxt = dbg_req ? S_DBG : S_DRAIN_C;
      S_DRAIN_C: begin
        state_nxt = !drain_done ? S_DRAIN_C : dbg_req ? S_DRAIN_D : S_CPU;
        cnt_nxt   = drain_done ? 3'd0 : cnt + 3'd1;
      end
      default:   state_nxt = S_CPU;
    endcase
  end
endmodule
